// File: rtl/mdio_master_param.sv
// MDIO management master: serialises a 32-bit frame with an optional preamble and captures read data.
// Optional Clause 45 ST=00 frames are enabled by defining MDIO_CLAUSE45_EN.
module mdio_master_param #(
    parameter int unsigned MDC_DIV      = 1,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        BUSY,
    output logic        ERR,
    output logic        MDC,
    output logic        MDIO_OE,
    output logic        MDIO_OUT
);

    localparam int unsigned    DivW    = $clog2(MDC_DIV + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(MDC_DIV - 1);
    localparam logic [5:0]     FirstBit = (PREAMBLE_LEN == 0) ? 6'd31 : 6'(PREAMBLE_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSend,
        StTaRx,
        StReceive,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              phase_q, phase_d;
    logic [5:0]        bit_q, bit_d;
    logic [31:0]       frame_q, frame_d;
    logic              rd_op_q, rd_op_d;
    logic              ta_err_q, ta_err_d;
    logic [15:0]       shift_q, shift_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              err_q, err_d;

    logic st_write, st_read;
    logic active, mdc_rise, bit_tick, finish;

    // Frame classification of the request currently presented on T_DATA.
    always_comb begin
        st_write = 1'b0;
        st_read  = 1'b0;
        if (T_DATA[31:30] == 2'b01) begin
            st_write = (T_DATA[29:28] == 2'b01);
            st_read  = (T_DATA[29:28] == 2'b10);
        end
`ifdef MDIO_CLAUSE45_EN
        if (T_DATA[31:30] == 2'b00) begin
            st_write = ~T_DATA[29];
            st_read  = T_DATA[29];
        end
`endif
    end

    assign active   = (state_q == StPreamble) || (state_q == StSend) ||
                      (state_q == StTaRx) || (state_q == StReceive);
    assign mdc_rise = active && !phase_q && (div_q == DivLast);
    assign bit_tick = active && phase_q && (div_q == DivLast);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        rd_op_d   = rd_op_q;
        ta_err_d  = ta_err_q;
        shift_d   = shift_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        finish    = 1'b0;

        if (active) begin
            if (div_q == DivLast) begin
                div_d   = '0;
                phase_d = ~phase_q;
            end else begin
                div_d = div_q + DivW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (MDIO_START) begin
                    if (st_write || st_read) begin
                        state_d  = (PREAMBLE_LEN == 0) ? StSend : StPreamble;
                        bit_d    = FirstBit;
                        frame_d  = T_DATA;
                        rd_op_d  = st_read;
                        ta_err_d = 1'b0;
                        div_d    = '0;
                        phase_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPreamble: begin
                if (bit_tick) begin
                    if (bit_q == 6'd0) begin
                        state_d = StSend;
                        bit_d   = 6'd31;
                    end else begin
                        bit_d = bit_q - 6'd1;
                    end
                end
            end
            StSend: begin
                if (bit_tick) begin
                    if (bit_q == 6'd0) begin
                        state_d = StDone;
                        finish  = 1'b1;
                    end else if (rd_op_q && (bit_q == 6'd18)) begin
                        // Last driven bit of a read: release the bus for turnaround.
                        state_d = StTaRx;
                        bit_d   = 6'd17;
                    end else begin
                        bit_d = bit_q - 6'd1;
                    end
                end
            end
            StTaRx: begin
                if (mdc_rise && (bit_q == 6'd16)) begin
                    ta_err_d = MDIO_IN;
                end
                if (bit_tick) begin
                    if (bit_q == 6'd16) begin
                        state_d = StReceive;
                        bit_d   = 6'd15;
                    end else begin
                        bit_d = bit_q - 6'd1;
                    end
                end
            end
            StReceive: begin
                if (mdc_rise) begin
                    shift_d = {shift_q[14:0], MDIO_IN};
                end
                if (bit_tick) begin
                    if (bit_q == 6'd0) begin
                        state_d = StDone;
                        finish  = 1'b1;
                    end else begin
                        bit_d = bit_q - 6'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                div_d   = '0;
                phase_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            err_d = rd_op_q & ta_err_q;
            if (rd_op_q && !ta_err_q) begin
                rd_data_d = shift_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= StIdle;
            div_q     <= '0;
            phase_q   <= 1'b0;
            bit_q     <= 6'd0;
            frame_q   <= 32'd0;
            rd_op_q   <= 1'b0;
            ta_err_q  <= 1'b0;
            shift_q   <= 16'd0;
            rd_data_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            rd_op_q   <= rd_op_d;
            ta_err_q  <= ta_err_d;
            shift_q   <= shift_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    assign BUSY     = (state_q != StIdle);
    assign DATA_RDY = (state_q == StDone);
    assign MDC      = active && phase_q;
    assign MDIO_OE  = (state_q == StPreamble) || (state_q == StSend);
    assign MDIO_OUT = (state_q == StSend) ? frame_q[bit_q[4:0]] : 1'b1;
    assign RD_DATA  = rd_data_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_mdio_master_param.sv
// Bench for mdio_master_param: default instance plus MDC_DIV=3 / no-preamble instance,
// checked cycle by cycle against a waveform model built from the frame bit list.
module tb_mdio_master_param;

    localparam int Div0 = 1;
    localparam int Pre0 = 32;
    localparam int Div1 = 3;
    localparam int Pre1 = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]       start;
    logic [1:0]       mdio_in;
    logic [1:0][31:0] tdata;

    logic [15:0] rd_data0, rd_data1;
    logic rdy0, rdy1, busy0, busy1, err0, err1, mdc0, mdc1, oe0, oe1, out0, out1;
    logic [1:0][15:0] rd_data;
    logic [1:0] data_rdy, busy, err, mdc, mdio_oe, mdio_out;

    assign rd_data  = {rd_data1, rd_data0};
    assign data_rdy = {rdy1, rdy0};
    assign busy     = {busy1, busy0};
    assign err      = {err1, err0};
    assign mdc      = {mdc1, mdc0};
    assign mdio_oe  = {oe1, oe0};
    assign mdio_out = {out1, out0};

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_rd [2];
    logic        exp_err [2];

    always #5 clk = ~clk;

    mdio_master_param #(.MDC_DIV(Div0), .PREAMBLE_LEN(Pre0)) u_dut0 (
        .CLK(clk), .RESET(rst_n), .MDIO_START(start[0]), .T_DATA(tdata[0]),
        .MDIO_IN(mdio_in[0]), .RD_DATA(rd_data0), .DATA_RDY(rdy0), .BUSY(busy0),
        .ERR(err0), .MDC(mdc0), .MDIO_OE(oe0), .MDIO_OUT(out0)
    );

    mdio_master_param #(.MDC_DIV(Div1), .PREAMBLE_LEN(Pre1)) u_dut1 (
        .CLK(clk), .RESET(rst_n), .MDIO_START(start[1]), .T_DATA(tdata[1]),
        .MDIO_IN(mdio_in[1]), .RD_DATA(rd_data1), .DATA_RDY(rdy1), .BUSY(busy1),
        .ERR(err1), .MDC(mdc1), .MDIO_OE(oe1), .MDIO_OUT(out1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit frame_valid(input logic [31:0] td);
        logic [1:0] st, op;
        st = td[31:30];
        op = td[29:28];
        frame_valid = (st == 2'b01) && (op == 2'b01 || op == 2'b10);
`ifdef MDIO_CLAUSE45_EN
        if (st == 2'b00) frame_valid = 1'b1;
`endif
    endfunction

    function automatic bit frame_read(input logic [31:0] td);
        logic [1:0] st, op;
        st = td[31:30];
        op = td[29:28];
        frame_read = (st == 2'b01) && (op == 2'b10);
`ifdef MDIO_CLAUSE45_EN
        if (st == 2'b00) frame_read = (op == 2'b10) || (op == 2'b11);
`endif
    endfunction

    // PHY side: turnaround Z reads as 1 (pull-up), then 0 if the PHY answers, then data.
    function automatic logic phy_bit(input int fb, input logic [15:0] d, input bit resp);
        if (fb <= 14) return 1'b1;
        if (fb == 15) return !resp;
        return resp ? d[31 - fb] : 1'b1;
    endfunction

    task automatic check_reset_vals(input int u);
        chk("rst_rd_data", rd_data[u], 16'h0);
        chk("rst_data_rdy", data_rdy[u], 0);
        chk("rst_busy", busy[u], 0);
        chk("rst_err", err[u], 0);
        chk("rst_mdc", mdc[u], 0);
        chk("rst_oe", mdio_oe[u], 0);
        chk("rst_out", mdio_out[u], 1);
    endtask

    task automatic run_frame(input int u, input logic [31:0] td, input logic [15:0] phy_data,
                             input bit resp, input int poke);
        int p, d, total, j, fb;
        bit rd, hi, e_oe;
        p  = (u == 0) ? Pre0 : Pre1;
        d  = (u == 0) ? Div0 : Div1;
        rd = frame_read(td);
        @(negedge clk);
        chk("idle_busy", busy[u], 0);
        chk("idle_rdy", data_rdy[u], 0);
        start[u]   = 1'b1;
        tdata[u]   = td;
        mdio_in[u] = 1'b1;
        if (!frame_valid(td)) begin
            @(negedge clk);
            start[u]   = 1'b0;
            exp_err[u] = 1'b1;
            chk("rej_err", err[u], 1);
            chk("rej_busy", busy[u], 0);
            chk("rej_rdy", data_rdy[u], 0);
            chk("rej_oe", mdio_oe[u], 0);
            repeat (3) begin
                @(negedge clk);
                chk("rej_mdc", mdc[u], 0);
                chk("rej_busy_hold", busy[u], 0);
            end
            chk("rej_rd_data", rd_data[u], exp_rd[u]);
            return;
        end
        total = (p + 32) * 2 * d;
        for (int n = 1; n <= total + 1; n++) begin
            @(negedge clk);
            start[u] = 1'b0;
            tdata[u] = td;
            if (n <= total) begin
                j  = (n - 1) / (2 * d);
                hi = ((n - 1) % (2 * d)) >= d;
                fb = j - p;
                mdio_in[u] = phy_bit(fb, phy_data, resp);
                e_oe = !(rd && fb >= 14);
                chk("mdc", mdc[u], hi);
                chk("busy", busy[u], 1);
                chk("data_rdy_early", data_rdy[u], 0);
                chk("mdio_oe", mdio_oe[u], e_oe);
                if (e_oe) chk("mdio_out", mdio_out[u], (fb < 0) ? 1'b1 : td[31 - fb]);
            end else begin
                if (rd && resp) exp_rd[u] = phy_data;
                exp_err[u] = rd && !resp;
                chk("done_rdy", data_rdy[u], 1);
                chk("done_busy", busy[u], 1);
                chk("done_mdc", mdc[u], 0);
                chk("done_oe", mdio_oe[u], 0);
                chk("done_out", mdio_out[u], 1);
                chk("done_err", err[u], exp_err[u]);
                chk("done_rd_data", rd_data[u], exp_rd[u]);
            end
            if (n == poke) begin
                // Request while busy must be ignored.
                start[u] = 1'b1;
                tdata[u] = 32'h6123_4567;
            end
        end
    endtask

    typedef struct {
        int          u;
        logic [31:0] td;
        logic [15:0] phy;
        bit          resp;
        bit          exp_err;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] r;
        logic [31:0] td;
        int u;
        start   = '0;
        mdio_in = '1;
        tdata   = '0;
        rst_n   = 1'b0;
        exp_rd[0]  = 16'h0;
        exp_rd[1]  = 16'h0;
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;

        vecs[0] = '{0, 32'h508A_ABCD, 16'h0000, 1, 0, 16'h0000};
        vecs[1] = '{0, 32'h6190_0000, 16'h1234, 1, 0, 16'h1234};
        vecs[2] = '{0, 32'h6190_0000, 16'hBEEF, 0, 1, 16'h1234};
        vecs[3] = '{0, 32'h7000_0000, 16'h0000, 1, 1, 16'h1234};
        vecs[4] = '{0, 32'hF000_0000, 16'h0000, 1, 1, 16'h1234};
        vecs[5] = '{0, 32'h508A_ABCD, 16'h0000, 1, 0, 16'h1234};
`ifdef MDIO_CLAUSE45_EN
        vecs[6] = '{0, 32'h3000_0000, 16'h5A5A, 1, 0, 16'h5A5A};
`else
        vecs[6] = '{0, 32'h3000_0000, 16'h5A5A, 1, 1, 16'h1234};
`endif
        vecs[7] = '{1, 32'h508A_ABCD, 16'h0000, 1, 0, 16'h0000};
        vecs[8] = '{1, 32'h6190_FFFF, 16'hC3A5, 1, 0, 16'hC3A5};

        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].u, vecs[i].td, vecs[i].phy, vecs[i].resp, (i == 5) ? 17 : 0);
            chk("vec_err", err[vecs[i].u], vecs[i].exp_err);
            chk("vec_rd_data", rd_data[vecs[i].u], vecs[i].exp_rd);
        end

        for (int i = 0; i < 12; i++) begin
            u = i % 2;
            r = $urandom();
            if (i % 4 == 3) td = r;
            else td = {2'b01, r[0] ? 2'b10 : 2'b01, r[27:0]};
            r = $urandom();
            run_frame(u, td, r[15:0], r[16] | r[17], (i % 3 == 0) ? int'($urandom_range(60, 1)) : 0);
            chk("rand_err", err[u], exp_err[u]);
        end

        // Reset in the middle of bit 20 of a write aborts without DATA_RDY.
        @(negedge clk);
        start[0] = 1'b1;
        tdata[0] = 32'h508A_ABCD;
        for (int n = 1; n <= 41; n++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        chk("pre_reset_busy", busy[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals(0);
        rst_n = 1'b1;
        exp_rd[0]  = 16'h0;
        exp_err[0] = 1'b0;
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            chk("post_reset_rdy", data_rdy[0], 0);
            chk("post_reset_busy", busy[0], 0);
        end
        run_frame(0, 32'h6190_0000, 16'hA55A, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
